// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM states, bus widths, pprot bit positions and
// response codes used by the register completer and its bench.
package apb_pkg;

    localparam int APB_DATA_W = 32;
    localparam int APB_STRB_W = 4;

    localparam int PPROT_PRIV   = 0;
    localparam int PPROT_NONSEC = 1;
    localparam int PPROT_INSTR  = 2;

    localparam logic RESP_OKAY = 1'b0;
    localparam logic RESP_ERR  = 1'b1;

    typedef enum logic {
        IDLE,
        ACCESS
    } apb_state_e;

endpackage

// File: rtl/apb_reg_slave_if.sv
// APB4 requester/completer signal bundle for a single psel bit.
interface apb_reg_slave_if
    import apb_pkg::*;
#(
    parameter int ADDR_W = 32
) ();

    logic                  psel;
    logic                  penable;
    logic [ADDR_W-1:0]     paddr;
    logic                  pwrite;
    logic [2:0]            pprot;
    logic [APB_DATA_W-1:0] pwdata;
    logic [APB_STRB_W-1:0] pstrb;
    logic [APB_DATA_W-1:0] prdata;
    logic                  pslverr;
    logic                  pready;

    modport master (
        output psel, penable, paddr, pwrite, pprot, pwdata, pstrb,
        input  prdata, pslverr, pready
    );

    modport slave (
        input  psel, penable, paddr, pwrite, pprot, pwdata, pstrb,
        output prdata, pslverr, pready
    );

endinterface

// File: rtl/apb_reg_bank.sv
// Byte-writable register bank; word 0 is a hardwired ID, the rest are storage.
module apb_reg_bank
    import apb_pkg::*;
#(
    parameter int                    NUM_REGS = 16,
    parameter int                    IDX_W    = $clog2(NUM_REGS),
    parameter logic [APB_DATA_W-1:0] ID_VALUE = 32'hA9B0_0001
) (
    input  logic                  pclk,
    input  logic                  preset,
    input  logic                  we,
    input  logic [IDX_W-1:0]      idx,
    input  logic [APB_DATA_W-1:0] wdata,
    input  logic [APB_STRB_W-1:0] strb,
    output logic [APB_DATA_W-1:0] rdata
);

    logic [APB_DATA_W-1:0] regs [1:NUM_REGS-1];

    // Clear storage on reset; otherwise commit only the strobed byte lanes.
    // NOTE: this array is reset on purpose -- software relies on reading 0
    // after reset, so it stays flops rather than an inferred RAM macro.
    always_ff @(posedge pclk) begin
        if (preset) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (idx != '0)) begin
            for (int b = 0; b < APB_STRB_W; b++) begin
                if (strb[b]) begin
                    regs[idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    // Combinational read port: value before any same-cycle write.
    assign rdata = (idx == '0) ? ID_VALUE : regs[idx];

endmodule

// File: rtl/apb_reg_slave.sv
// APB4 completer: captures the setup phase, waits WAIT_STATES access cycles,
// then completes with read data or an error and commits error-free writes.
module apb_reg_slave
    import apb_pkg::*;
#(
    parameter int                    NUM_REGS    = 16,
    parameter int                    ADDR_W      = 32,
    parameter int                    WAIT_STATES = 0,
    parameter logic [APB_DATA_W-1:0] ID_VALUE    = 32'hA9B0_0001,
    parameter int                    PROT_CHECK  = 1
) (
    input  logic             pclk,
    input  logic             preset,
    apb_reg_slave_if.slave   apb
);

    localparam int IDX_W  = $clog2(NUM_REGS);
    localparam int WORD_W = ADDR_W - 2;
    localparam logic [WORD_W-1:0] NUM_WORDS = WORD_W'(NUM_REGS);

    apb_state_e            state, state_next;
    logic [3:0]            wait_cnt, wait_cnt_next;
    logic                  capture;
    logic                  reg_we;
    logic                  err;

    logic [ADDR_W-1:0]     addr_q;
    logic                  write_q;
    logic                  priv_q;
    logic [APB_DATA_W-1:0] wdata_q;
    logic [APB_STRB_W-1:0] strb_q;

    logic [WORD_W-1:0]     word_idx;
    logic [APB_DATA_W-1:0] reg_rdata;

    // State and wait counter; synchronous reset aborts any access.
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge pclk) begin
        if (preset) begin
            state    <= IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
        end
    end

    // Hold the setup-phase request for the whole access.
    always_ff @(posedge pclk) begin
        if (capture) begin
            addr_q  <= apb.paddr;
            write_q <= apb.pwrite;
            priv_q  <= apb.pprot[PPROT_PRIV];
            wdata_q <= apb.pwdata;
            strb_q  <= apb.pstrb;
        end
    end

    assign word_idx = addr_q[ADDR_W-1:2];

    // Decode errors from the latched request.
    always_comb begin
        err = (addr_q[1:0] != 2'b00)
           || (word_idx >= NUM_WORDS)
           || (write_q && (word_idx == '0))
           || ((PROT_CHECK != 0) && write_q && !priv_q);
    end

    // Next state, counter and bus responses; outputs are zero unless completing.
    // NOTE: every output gets a default first so no path can infer a latch.
    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        capture       = 1'b0;
        reg_we        = 1'b0;
        apb.pready    = 1'b0;
        apb.pslverr   = RESP_OKAY;
        apb.prdata    = '0;
        case (state)
            IDLE: begin
                if (apb.psel && !apb.penable) begin
                    capture       = 1'b1;
                    wait_cnt_next = 4'(WAIT_STATES);
                    state_next    = ACCESS;
                end
            end
            ACCESS: begin
                if (!apb.psel) begin
                    state_next = IDLE;
                end else if (apb.penable) begin
                    if (wait_cnt != 4'd0) begin
                        wait_cnt_next = wait_cnt - 4'd1;
                    end else begin
                        apb.pready  = 1'b1;
                        apb.pslverr = err ? RESP_ERR : RESP_OKAY;
                        apb.prdata  = (!write_q && !err) ? reg_rdata : '0;
                        reg_we      = write_q && !err;
                        state_next  = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    apb_reg_bank #(
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W),
        .ID_VALUE (ID_VALUE)
    ) u_bank (
        .pclk   (pclk),
        .preset (preset),
        .we     (reg_we),
        .idx    (word_idx[IDX_W-1:0]),
        .wdata  (wdata_q),
        .strb   (strb_q),
        .rdata  (reg_rdata)
    );

endmodule
